mo_mul_arb: RTL and testbench

MO_MUL_ARB -- requirements
Module: mo_mul_arb

---
 rtl/ntt_pkg.sv | 29 ++
 rtl/mo_mul.sv | 65 ++++++
 rtl/mo_mul_arb.sv | 152 +++++++++++++++
 tb/tb_mo_mul_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the modular-multiplier arbiter slice.
//   DATA_WIDTH : operand / result width
//   Q          : modulus (NTT-friendly prime, 12289 = 3*2^12 + 1)
//   Q_M        : -Q^-1 mod 2^DATA_WIDTH (Montgomery constant)
//   Q_K        : bit length of Q
//   tag_t      : {valid, requester index} carried alongside the multiplier pipeline
//   arb_state_e: issue/drain FSM states
package ntt_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam logic [DATA_WIDTH-1:0] Q = 16'd12289;
  localparam logic [DATA_WIDTH-1:0] Q_M = 16'd12287;
  localparam int unsigned Q_K = 14;

  // Wide enough for up to 8 requesters.
  localparam int unsigned IDX_W = 3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDrained
  } arb_state_e;

endpackage

// File: rtl/mo_mul.sv
// Fully pipelined radix-2 Montgomery multiplier: p = a * b * 2^-WIDTH mod Q.
// Latency WIDTH+2 cycles (input register, WIDTH reduction stages, final subtract),
// one new operand pair accepted every cycle.
//   clk : clock
//   a_i : operand a, must lie in 0..Q
//   b_i : operand b, any WIDTH-bit value
//   p_o : result, fully reduced into 0..Q-1
module mo_mul
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  // Running value stays below b + Q; the pre-halving sum needs one more bit.
  localparam int unsigned TW = WIDTH + 2;
  localparam logic [TW-1:0] QT = TW'(Q);

  logic [WIDTH-1:0] a_q [WIDTH];
  logic [WIDTH-1:0] a_d [WIDTH];
  logic [WIDTH-1:0] b_q [WIDTH];
  logic [WIDTH-1:0] b_d [WIDTH];
  logic [TW-1:0]    t_q [1:WIDTH];
  logic [TW-1:0]    t_d [1:WIDTH];
  logic [WIDTH-1:0] p_q, p_d;

  // One bit of a: add b if set, add Q if odd so the halving is exact.
  function automatic logic [TW-1:0] mont_step(logic [TW-1:0] t, logic a_bit,
                                              logic [WIDTH-1:0] b);
    logic [TW-1:0] s;
    s = t + (a_bit ? TW'(b) : '0);
    if (s[0]) s = s + QT;
    return s >> 1;
  endfunction

  always_comb begin
    a_d[0] = a_i;
    b_d[0] = b_i;
    for (int s = 1; s < WIDTH; s++) begin
      a_d[s] = a_q[s-1] >> 1;
      b_d[s] = b_q[s-1];
    end
    t_d[1] = mont_step('0, a_q[0][0], b_q[0]);
    for (int s = 2; s <= WIDTH; s++) begin
      t_d[s] = mont_step(t_q[s-1], a_q[s-1][0], b_q[s-1]);
    end
    // With a <= Q the Montgomery result is below 2Q, so one subtract suffices.
    p_d = WIDTH'((t_q[WIDTH] >= QT) ? t_q[WIDTH] - QT : t_q[WIDTH]);
  end

  // Pure datapath: validity is tracked by the caller, so no reset is needed.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    t_q <= t_d;
    p_q <= p_d;
  end

  assign p_o = p_q;

endmodule

// File: rtl/mo_mul_arb.sv
// Arbiter sharing one pipelined Montgomery multiplier among NUM_REQ requesters.
// A tag pipeline of depth MUL_LAT routes each result back to its issuer; a
// drain request stops issue and reports when the pipeline is empty.
// Build option: define MO_MUL_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins).
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester grant (at most one bit), combinational
//   req_a/b    : per-requester operands
//   rsp_valid  : one-hot result strobe to the issuing requester
//   rsp_data   : shared result bus
//   drain      : level request to stop issuing and empty the pipeline
//   drained    : high while in the drained state
//   inflight   : issued-but-not-returned operation count
module mo_mul_arb
  import ntt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MUL_LAT = DATA_WIDTH + 2,
  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  input  logic                                drain,
  output logic                                drained,
  output logic [CNT_W-1:0]                    inflight
);

  arb_state_e       state_q, state_d;
  tag_t             tag_q [MUL_LAT];
  tag_t             tag_d [MUL_LAT];
  logic [CNT_W-1:0] inflight_q, inflight_d;

  logic [IDX_W-1:0]      start;
  logic [NUM_REQ-1:0]    rot;
  logic [IDX_W:0]        sum;
  logic                  gnt_found;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  issue;
  tag_t                  rsp_tag;
  logic [DATA_WIDTH-1:0] mul_a, mul_b;

`ifdef MO_MUL_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = '0;
`endif

  // Rotate requests so the search always starts at bit 0, then map back.
  always_comb begin
    rot       = NUM_REQ'({req_valid, req_valid} >> start);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && rot[k]) begin
        gnt_found = 1'b1;
        sum       = {1'b0, start} + (IDX_W+1)'(k);
        gnt_idx   = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                 : IDX_W'(sum);
      end
    end
  end

  assign issue   = (state_q == StRun) && gnt_found;
  assign rsp_tag = tag_q[MUL_LAT-1];

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = issue && (gnt_idx == IDX_W'(i));
      rsp_valid[i] = rsp_tag.valid && (rsp_tag.idx == IDX_W'(i));
      if (gnt_idx == IDX_W'(i)) begin
        mul_a = req_a[i];
        mul_b = req_b[i];
      end
    end
  end

  always_comb begin
    tag_d[0] = '{valid: issue, idx: gnt_idx};
    for (int k = 1; k < MUL_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    inflight_d = inflight_q;
    if (issue && !rsp_tag.valid) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!issue && rsp_tag.valid) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    state_d = state_q;
    unique case (state_q)
      StRun:     if (drain) state_d = StDrain;
      // Enter DRAINED in the same cycle the count reaches zero.
      StDrain:   if (!drain) state_d = StRun;
                 else if (inflight_d == '0) state_d = StDrained;
      StDrained: if (!drain) state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

`ifdef MO_MUL_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      inflight_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) tag_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  assign drained  = (state_q == StDrained);
  assign inflight = inflight_q;

  mo_mul #(
    .WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk(clk),
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(rsp_data)
  );

endmodule

// File: tb/tb_mo_mul_arb.sv
// Self-checking bench for mo_mul_arb: arbitration table, directed sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_mo_mul_arb;
  import ntt_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = DATA_WIDTH + 2;
  localparam int unsigned CW  = $clog2(LAT + 1);

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [N-1:0]                  req_valid = '0;
  logic [N-1:0]                  req_ready;
  logic [N-1:0][DATA_WIDTH-1:0]  req_a = '0;
  logic [N-1:0][DATA_WIDTH-1:0]  req_b = '0;
  logic [N-1:0]                  rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          drain = 1'b0;
  logic                          drained;
  logic [CW-1:0]                 inflight;

  always #10 clk = ~clk;

  mo_mul_arb #(
    .NUM_REQ(N),
    .MUL_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .drain(drain),
    .drained(drained),
    .inflight(inflight)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned due;
    int          idx;
    longint      data;
  } pend_t;

  pend_t       pq[$];
  int          m_state = 0;  // 0 run, 1 draining, 2 drained
  int          m_ptr = 0;
  int unsigned cyc = 0;
  longint      rinv = 0;
  longint      peak = 0;
  logic [N-1:0] last_ready;
  int          resp_count = 0;
  bit          drained_seen = 0;

  function automatic longint mont_ref(longint a, longint b);
    return (((a * b) % longint'(Q)) * rinv) % longint'(Q);
  endfunction

  function automatic int model_grant(logic [N-1:0] v);
    int j;
    if (m_state != 0) return -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (((v >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  // One clock cycle with the currently driven inputs.
  task automatic step();
    int     g;
    longint ea, eb;
    @(negedge clk);
    g = model_grant(req_valid);
    check("req_ready", req_ready, (g < 0) ? 0 : (longint'(1) << g));
    if (pq.size() > 0 && pq[0].due == cyc) begin
      check("rsp_valid", rsp_valid, longint'(1) << pq[0].idx);
      check("rsp_data", rsp_data, pq[0].data);
    end else begin
      check("rsp_valid_idle", rsp_valid, 0);
    end
    check("inflight", inflight, pq.size());
    check("drained", drained, (m_state == 2) ? 1 : 0);
    if (inflight > peak) peak = inflight;
    if (rsp_valid != 0) resp_count++;
    if (drained) drained_seen = 1;
    last_ready = req_ready;
    ea = 0;
    eb = 0;
    for (int i = 0; i < N; i++) begin
      if (i == g) begin
        ea = req_a[i];
        eb = req_b[i];
      end
    end
    @(posedge clk);
    if (pq.size() > 0 && pq[0].due == cyc) void'(pq.pop_front());
    if (g >= 0) begin
      pq.push_back('{due: cyc + LAT, idx: g, data: mont_ref(ea, eb)});
`ifdef MO_MUL_ARB_RR_EN
      m_ptr = (g + 1) % N;
`endif
    end
    case (m_state)
      0: if (drain) m_state = 1;
      1: if (!drain) m_state = 0; else if (pq.size() == 0) m_state = 2;
      default: if (!drain) m_state = 0;
    endcase
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    drain = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pq.delete();
    m_state = 0;
    m_ptr = 0;
    cyc++;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i] = DATA_WIDTH'($urandom_range(0, int'(Q)));
      req_b[i] = DATA_WIDTH'($urandom);
    end
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] exp;
  } vec_t;

  vec_t         tbl[10];
  logic [N-1:0] exp_b[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    for (longint x = 1; x < longint'(Q); x++) begin
      if (((x << DATA_WIDTH) % longint'(Q)) == 1) rinv = x;
    end

    // Grant from a freshly reset pointer: lowest set bit in both builds.
    tbl = '{'{4'b0001, 4'b0001}, '{4'b0010, 4'b0010}, '{4'b0110, 4'b0010},
            '{4'b1000, 4'b1000}, '{4'b1100, 4'b0100}, '{4'b1111, 4'b0001},
            '{4'b1010, 4'b0010}, '{4'b0000, 4'b0000}, '{4'b0101, 4'b0001},
            '{4'b1110, 4'b0010}};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v;
      #1;
      check("table_ready", req_ready, tbl[i].exp);
    end
    req_valid = '0;
    @(posedge clk);
    #1;
    cyc++;

    // Reset state and single zero-operand transaction.
    step();
    req_valid = 4'b0001;
    req_a[0] = '0;
    req_b[0] = 16'd5;
    step();
    req_valid = '0;
    repeat (LAT + 2) step();

    // All four requesting every cycle.
    do_reset();
    rand_ops();
    req_valid = 4'b1111;
`ifdef MO_MUL_ARB_RR_EN
    exp_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`else
    exp_b = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      check("grant_seq", last_ready, exp_b[i]);
    end
    req_valid = 4'b1110;
    step();
`ifndef MO_MUL_ARB_RR_EN
    check("prio_drop0", last_ready, 4'b0010);
`endif
    req_valid = '0;
    repeat (LAT + 1) step();

    // Random back-to-back traffic.
    peak = 0;
    for (int c = 0; c < 3 * LAT; c++) begin
      rand_ops();
      req_valid = N'($urandom_range(1, 15));
      step();
    end
    req_valid = '0;
    repeat (LAT + 1) step();
    check("inflight_peak", peak, LAT);

    // Five issues, drain raised together with the fifth.
    resp_count = 0;
    drained_seen = 0;
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      rand_ops();
      if (c == 4) drain = 1'b1;
      step();
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 60 && !drained_seen; k++) step();
    check("drain_done", drained_seen, 1);
    check("drain_resp_count", resp_count, 5);
    drain = 1'b0;
    step();
    step();
    check("grant_resume", (last_ready != 0) ? 1 : 0, 1);
    req_valid = '0;
    repeat (LAT + 1) step();

    // Reset discards in-flight work.
    req_valid = 4'b0110;
    repeat (3) begin
      rand_ops();
      step();
    end
    do_reset();
    resp_count = 0;
    repeat (LAT + 3) step();
    check("post_reset_resp", resp_count, 0);
    req_valid = 4'b1111;
    step();
    check("post_reset_grant", last_ready, 4'b0001);
    req_valid = '0;
    repeat (LAT + 1) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
